// File: rtl/rng_lfsr_32.sv
// 24-bit Fibonacci LFSR, taps {23,17,5,0}, emitting unsigned Q8.24
// samples in [0,1); seeded while reset is low, output one step behind.
module rng_lfsr_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] lfsr,
  output logic [31:0] rand_q8_24
);

  logic [31:0] state;
  logic [31:0] out_q;
  logic [31:0] nxt;
  logic        fb;

  assign fb  = state[23] ^ state[17]
             ^ state[5]  ^ state[0];
  assign nxt = {8'h00, state[22:0], fb};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= lfsr;
      out_q <= lfsr;
    end else if (en) begin
      out_q <= state;
      state <= nxt;
    end
  end

  // Bypass keeps seed changes visible while held in reset
  assign rand_q8_24 = reset ? out_q : lfsr;

endmodule

// File: tb/tb_rng_lfsr_32.sv
// Self-checking bench for rng_lfsr_32: step-count model plus
// directed literal vectors from hand-computed sequences.
module tb_rng_lfsr_32;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] lfsr;
  logic [31:0] rand_q8_24;

  int checks = 0;
  int errs   = 0;

  logic [31:0] mseed;
  int          k;
  bit          run_chk = 0;

  rng_lfsr_32 dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .lfsr       (lfsr),
    .rand_q8_24 (rand_q8_24)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] adv(input logic [31:0] s);
    longint v;
    longint f;
    v = longint'(s) % (64'd1 << 24);
    f = ((v >> 23) + (v >> 17) + (v >> 5) + v) % 2;
    return 32'((v * 2) % (64'd1 << 24) + f);
  endfunction

  // Sample k after release: k=0 is the seed, k>=1 is S_{k-1}
  function automatic logic [31:0] samp(input logic [31:0] seed,
                                       input int n);
    logic [31:0] s;
    s = seed;
    for (int j = 1; j < n; j++) s = adv(s);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h expected %h t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k     <= 0;
      mseed <= lfsr;
    end else if (en) begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      if (!reset) chk("model_rst", rand_q8_24, lfsr);
      else chk("model", rand_q8_24, samp(mseed, k));
      if (reset && k >= 2)
        chk("hi_zero", {24'h0, rand_q8_24[31:24]}, 32'h0);
    end
  end

  task automatic edge_chk(input string name,
                          input logic [31:0] exp);
    @(posedge clk);
    @(negedge clk);
    chk(name, rand_q8_24, exp);
  endtask

  task automatic reseed(input logic [31:0] s);
    @(posedge clk);
    #2;
    lfsr  = s;
    reset = 0;
    en    = 1;
    #1 chk("rst_now", rand_q8_24, s);
    @(posedge clk);
    #2 reset = 1;
  endtask

  logic [31:0] rs;

  initial begin
    reset = 0;
    en    = 0;
    lfsr  = 32'h0000_0001;
    #1 chk("rst_init", rand_q8_24, 32'h1);
    repeat (2) @(posedge clk);
    run_chk = 1;
    #2;
    reset = 1;
    en    = 1;
    edge_chk("s1_e1", 32'h0000_0001);
    edge_chk("s1_e2", 32'h0000_0003);
    edge_chk("s1_e3", 32'h0000_0007);
    edge_chk("s1_e4", 32'h0000_000F);
    edge_chk("s1_e5", 32'h0000_001F);

    reseed(32'hFF00_0000);
    edge_chk("lk_e1", 32'hFF00_0000);
    edge_chk("lk_e2", 32'h0000_0000);
    edge_chk("lk_e3", 32'h0000_0000);
    edge_chk("lk_e4", 32'h0000_0000);

    reseed(32'h0080_0000);
    edge_chk("b23_e1", 32'h0080_0000);
    edge_chk("b23_e2", 32'h0000_0001);
    edge_chk("b23_e3", 32'h0000_0003);

    rs = $urandom;
    if (rs[23:0] == 24'h0) rs = 32'hA5_00_00_01;
    reseed(rs);
    repeat (20) @(posedge clk);

    #2 en = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall", rand_q8_24, samp(rs, 20));
    @(posedge clk);
    #2 en = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("resume", rand_q8_24, samp(rs, 24));

    // Asynchronous abort between edges
    @(posedge clk);
    #3;
    lfsr  = 32'h1234_5678;
    reset = 0;
    #1 chk("async", rand_q8_24, 32'h1234_5678);
    lfsr = 32'h0000_0001;
    #1 chk("transp", rand_q8_24, 32'h0000_0001);
    @(posedge clk);
    #2 reset = 1;
    edge_chk("rs_e1", 32'h0000_0001);
    edge_chk("rs_e2", 32'h0000_0003);
    repeat (5) @(posedge clk);
    @(negedge clk);
    run_chk = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
